sample_dac_tx: RTL and testbench
================================

SAMPLE_DAC_TX -- requirements
Module: sample_dac_tx

Interface
REQ-001 Parameter CLK_DIV, default 2: clk cycles per dacSclk half-period; legal range 1..255.
REQ-002 Parameter DAC_CONFIG, default 4'b0111: the four command bits sent ahead of each sample.
REQ-003 Port clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port inSample  input  12  unsigned sample from filter output.
REQ-006 Port inSampleReady  input  1  sample-valid level; rising edge (sampled on clk) requests a frame.
REQ-007 Port dacCsN  output  1  DAC chip select, active-low.
REQ-008 Port dacSclk  output  1  serial clock, idle low.
REQ-009 Port dacMosi  output  1  serial data, MSB first.
REQ-010 Port dacLdacN  output  1  DAC latch strobe, active-low.
REQ-011 Port busy  output  1  high while a frame is in progress.
REQ-012 Port overrun  output  1  one-cycle pulse when a sample is lost or overwritten.

Function
REQ-013 Edge detect SHALL register inSampleReady once; a request is inSampleReady=1 with the registered copy 0.
REQ-014 A level held high SHALL produce exactly one request.
REQ-015 FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, LDAC; all outputs registered.
REQ-016 IDLE + request: latch frame = {DAC_CONFIG, inSample}; go to CS_SETUP; dacCsN=0 and busy=1 from that edge.
REQ-017 CS_SETUP SHALL last CLK_DIV cycles with dacMosi = frame bit 15 and dacSclk=0.
REQ-018 SHIFT SHALL produce 16 dacSclk pulses: each half-period CLK_DIV cycles, low half first; dacMosi changes only at falling edges and is stable across each rising edge; bit 15 first, bit 0 last.
REQ-019 CS_HOLD SHALL start at the 16th falling edge, with dacSclk=0, and last CLK_DIV cycles; dacCsN then returns high.
REQ-020 LDAC SHALL drive dacLdacN=0 for CLK_DIV cycles with dacCsN=1; then return to IDLE with busy=0.
REQ-021 Frame length SHALL be exactly 35*CLK_DIV cycles of busy=1 (70 at default).
REQ-022 Divider counter width SHALL be 8 bits; the bit counter SHALL count 0..15 without wrapping into a 17th bit.
REQ-023 A request in any non-IDLE state, including the last LDAC cycle, SHALL be treated as arriving while busy (see REQ-027/028).
REQ-024 dacMosi SHALL be 0 in IDLE and LDAC.

Reset
REQ-025 rst SHALL immediately force IDLE: dacCsN=1, dacSclk=0, dacMosi=0, dacLdacN=1, busy=0, overrun=0, frame and skid registers cleared.
REQ-026 The registered inSampleReady copy SHALL reset to 1, so a level already high at reset release starts no frame; a frame in progress at reset is abandoned, not resumed.

Configuration
REQ-027 Macro SAMPLE_DAC_TX_SKID_EN defined: a request while busy SHALL be stored in a one-deep skid register; a newer request overwrites it and pulses overrun; at LDAC exit a pending skid sample SHALL go directly to CS_SETUP with no IDLE cycle.
REQ-028 Macro undefined: a request while busy SHALL be dropped and overrun SHALL pulse for one cycle; no skid register exists.

Verification
REQ-029 Default params, inSample=12'hA5C with one rising edge -> dacMosi shifts 16'h7A5C MSB first, 16 dacSclk rising edges, busy high exactly 70 cycles, dacLdacN low 2 cycles after dacCsN rises.
REQ-030 DAC_CONFIG=4'b1011, CLK_DIV=1, inSample=12'hFFF -> frame 16'hBFFF, busy 35 cycles.
REQ-031 Skid undefined: second edge (12'h123) 10 cycles after first -> one overrun pulse, only the 16'h7A5C frame is sent.
REQ-032 Skid defined: same stimulus -> frames 16'h7A5C then 16'h7123 back-to-back, busy continuously high for 140 cycles, no overrun; a third edge before the first frame ends -> overrun pulse, last sample sent.
REQ-033 inSampleReady held high for 200 cycles -> exactly one frame; rst asserted mid-SHIFT -> outputs at reset values immediately, no frame after release while inSampleReady stays high.

Source files
------------

// File: rtl/sample_dac_tx.sv
//------------------------------------------------------------------------------
// Module      : sample_dac_tx
// Description : Serialises 12-bit filter samples into 16-bit DAC command
//               frames {DAC_CONFIG, sample} over an SPI-style link
//               (dacCsN / dacSclk / dacMosi) and then strobes dacLdacN.
//               Optional macro SAMPLE_DAC_TX_SKID_EN adds a one-deep skid
//               register that holds a sample arriving while a frame is in
//               flight; without it such samples are dropped.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sample_dac_tx #(
    parameter int unsigned CLK_DIV    = 2,
    parameter logic [3:0]  DAC_CONFIG = 4'b0111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] inSample,
    input  logic        inSampleReady,
    output logic        dacCsN,
    output logic        dacSclk,
    output logic        dacMosi,
    output logic        dacLdacN,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CS_SETUP = 3'd1,
        S_SHIFT    = 3'd2,
        S_CS_HOLD  = 3'd3,
        S_LDAC     = 3'd4
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q;
    logic [7:0]  div_q;
    logic [3:0]  bit_q;
    logic [14:0] frame_q;     // bits still to be shifted after the one on dacMosi
    logic        rdy_q;
    logic        csn_q;
    logic        sclk_q;
    logic        mosi_q;
    logic        ldacn_q;
    logic        busy_q;
    logic        overrun_q;

    logic        req;
    logic        div_done;

    assign req      = inSampleReady & ~rdy_q;
    assign div_done = (div_q == DIV_LAST);

`ifdef SAMPLE_DAC_TX_SKID_EN
    logic        skid_valid_q;
    logic [11:0] skid_data_q;
    logic [11:0] next_sample_d;

    // A request landing on the LDAC exit cycle is newer than the skid entry.
    assign next_sample_d = req ? inSample : skid_data_q;
`endif

    assign dacCsN   = csn_q;
    assign dacSclk  = sclk_q;
    assign dacMosi  = mosi_q;
    assign dacLdacN = ldacn_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

    // Frame sequencer: edge detect, divider, bit counter and all output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            frame_q      <= '0;
            rdy_q        <= 1'b1;   // a level already high at release is not an edge
            csn_q        <= 1'b1;
            sclk_q       <= 1'b0;
            mosi_q       <= 1'b0;
            ldacn_q      <= 1'b1;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SAMPLE_DAC_TX_SKID_EN
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
`endif
        end else begin
            rdy_q     <= inSampleReady;
            overrun_q <= 1'b0;

            // Requests outside IDLE either park in the skid slot or are lost.
            if (req && (state_q != S_IDLE)) begin
`ifdef SAMPLE_DAC_TX_SKID_EN
                skid_valid_q <= 1'b1;
                skid_data_q  <= inSample;
                if (skid_valid_q) begin
                    overrun_q <= 1'b1;
                end
`else
                overrun_q <= 1'b1;
`endif
            end

            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_q <= S_CS_SETUP;
                        frame_q <= {DAC_CONFIG[2:0], inSample};
                        mosi_q  <= DAC_CONFIG[3];
                        csn_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        div_q   <= '0;
                        bit_q   <= '0;
                    end
                end

                S_CS_SETUP: begin
                    if (div_done) begin
                        div_q   <= '0;
                        state_q <= S_SHIFT;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

                S_SHIFT: begin
                    if (div_done) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            // Falling edge: advance data so it is settled before the next rise.
                            sclk_q <= 1'b0;
                            if (bit_q == 4'd15) begin
                                state_q <= S_CS_HOLD;
                                mosi_q  <= 1'b0;
                            end else begin
                                bit_q   <= bit_q + 4'd1;
                                mosi_q  <= frame_q[14];
                                frame_q <= {frame_q[13:0], 1'b0};
                            end
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

                S_CS_HOLD: begin
                    if (div_done) begin
                        div_q   <= '0;
                        csn_q   <= 1'b1;
                        ldacn_q <= 1'b0;
                        state_q <= S_LDAC;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

                S_LDAC: begin
                    if (div_done) begin
                        div_q   <= '0;
                        ldacn_q <= 1'b1;
`ifdef SAMPLE_DAC_TX_SKID_EN
                        if (req || skid_valid_q) begin
                            // Chain straight into the next frame; busy stays high.
                            state_q      <= S_CS_SETUP;
                            frame_q      <= {DAC_CONFIG[2:0], next_sample_d};
                            mosi_q       <= DAC_CONFIG[3];
                            csn_q        <= 1'b0;
                            bit_q        <= '0;
                            skid_valid_q <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
`else
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sample_dac_tx.sv
//------------------------------------------------------------------------------
// Module      : tb_sample_dac_tx
// Description : Directed self-checking bench for sample_dac_tx. Instance u_dut0
//               uses default parameters, u_dut1 uses CLK_DIV=1 and
//               DAC_CONFIG=4'b1011. Skid-dependent expectations follow the
//               SAMPLE_DAC_TX_SKID_EN macro.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sample_dac_tx;

    logic        clk;
    logic        rst;
    logic [11:0] sample0, sample1;
    logic        ready0, ready1;
    logic        csn0, sclk0, mosi0, ldacn0, busy0, ovr0;
    logic        csn1, sclk1, mosi1, ldacn1, busy1, ovr1;

    int tests;
    int fails;

    // Observation statistics for each instance, gathered once per cycle.
    int          busy_cnt0, run0, max_run0, rise_cnt0, ovr_cnt0, ldac_cnt0, ldac_bad0, mosi_bad0;
    logic [63:0] bits0;
    logic        prev_sclk0, prev_mosi0;
    int          busy_cnt1, rise_cnt1, ldac_cnt1;
    logic [63:0] bits1;
    logic        prev_sclk1;

    sample_dac_tx u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .inSample     (sample0),
        .inSampleReady(ready0),
        .dacCsN       (csn0),
        .dacSclk      (sclk0),
        .dacMosi      (mosi0),
        .dacLdacN     (ldacn0),
        .busy         (busy0),
        .overrun      (ovr0)
    );

    sample_dac_tx #(
        .CLK_DIV   (1),
        .DAC_CONFIG(4'b1011)
    ) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .inSample     (sample1),
        .inSampleReady(ready1),
        .dacCsN       (csn1),
        .dacSclk      (sclk1),
        .dacMosi      (mosi1),
        .dacLdacN     (ldacn1),
        .busy         (busy1),
        .overrun      (ovr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_stats();
        busy_cnt0 = 0; run0 = 0; max_run0 = 0; rise_cnt0 = 0; ovr_cnt0 = 0;
        ldac_cnt0 = 0; ldac_bad0 = 0; mosi_bad0 = 0; bits0 = '0;
        prev_sclk0 = sclk0; prev_mosi0 = mosi0;
        busy_cnt1 = 0; rise_cnt1 = 0; ldac_cnt1 = 0; bits1 = '0;
        prev_sclk1 = sclk1;
    endtask

    // Advance to the next falling clk edge and fold the outputs into the statistics.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy0) begin
                busy_cnt0++; run0++;
                if (run0 > max_run0) max_run0 = run0;
            end else begin
                run0 = 0;
            end
            if (sclk0 && !prev_sclk0) begin
                bits0 = {bits0[62:0], mosi0};
                rise_cnt0++;
                if (mosi0 !== prev_mosi0) mosi_bad0++;
            end
            if (ovr0) ovr_cnt0++;
            if (!ldacn0) begin
                ldac_cnt0++;
                if (!csn0) ldac_bad0++;
            end
            prev_sclk0 = sclk0;
            prev_mosi0 = mosi0;
            if (busy1) busy_cnt1++;
            if (sclk1 && !prev_sclk1) begin
                bits1 = {bits1[62:0], mosi1};
                rise_cnt1++;
            end
            if (!ldacn1) ldac_cnt1++;
            prev_sclk1 = sclk1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ready0 = 1'b0; ready1 = 1'b0; sample0 = '0; sample1 = '0;
        step(3);
        tests++; if (csn0 !== 1'b1)   begin fails++; $display("FAIL reset_csn got %b want 1", csn0); end
        tests++; if (sclk0 !== 1'b0)  begin fails++; $display("FAIL reset_sclk got %b want 0", sclk0); end
        tests++; if (mosi0 !== 1'b0)  begin fails++; $display("FAIL reset_mosi got %b want 0", mosi0); end
        tests++; if (ldacn0 !== 1'b1) begin fails++; $display("FAIL reset_ldacn got %b want 1", ldacn0); end
        tests++; if (busy0 !== 1'b0)  begin fails++; $display("FAIL reset_busy got %b want 0", busy0); end
        tests++; if (ovr0 !== 1'b0)   begin fails++; $display("FAIL reset_overrun got %b want 0", ovr0); end
        rst = 1'b0;
        step(3);
    endtask

    task automatic test_single_frame();
        clear_stats();
        sample0 = 12'hA5C; ready0 = 1'b1;
        step(1);
        tests++; if (busy0 !== 1'b1 || csn0 !== 1'b0 || mosi0 !== 1'b0)
            begin fails++; $display("FAIL single_start busy=%b csn=%b mosi=%b want 1 0 0", busy0, csn0, mosi0); end
        step(149);
        tests++; if (bits0[15:0] !== 16'h7A5C) begin fails++; $display("FAIL single_data got %h want 7a5c", bits0[15:0]); end
        tests++; if (rise_cnt0 != 16)  begin fails++; $display("FAIL single_rises got %0d want 16", rise_cnt0); end
        tests++; if (busy_cnt0 != 70 || max_run0 != 70)
            begin fails++; $display("FAIL single_busy got %0d/%0d want 70/70", busy_cnt0, max_run0); end
        tests++; if (ldac_cnt0 != 2 || ldac_bad0 != 0)
            begin fails++; $display("FAIL single_ldac got %0d bad %0d want 2 bad 0", ldac_cnt0, ldac_bad0); end
        tests++; if (ovr_cnt0 != 0)    begin fails++; $display("FAIL single_overrun got %0d want 0", ovr_cnt0); end
        tests++; if (mosi_bad0 != 0)   begin fails++; $display("FAIL single_mosi_stable got %0d want 0", mosi_bad0); end
        ready0 = 1'b0;
        step(3);
    endtask

    task automatic test_level_hold();
        clear_stats();
        sample0 = 12'h3C1; ready0 = 1'b1;
        step(200);
        tests++; if (rise_cnt0 != 16 || busy_cnt0 != 70)
            begin fails++; $display("FAIL hold_one_frame rises %0d busy %0d want 16 70", rise_cnt0, busy_cnt0); end
        tests++; if (bits0[15:0] !== 16'h73C1) begin fails++; $display("FAIL hold_data got %h want 73c1", bits0[15:0]); end
        ready0 = 1'b0;
        step(3);
    endtask

    task automatic test_config_div1();
        clear_stats();
        sample1 = 12'hFFF; ready1 = 1'b1;
        step(1);
        tests++; if (busy1 !== 1'b1 || mosi1 !== 1'b1)
            begin fails++; $display("FAIL div1_start busy=%b mosi=%b want 1 1", busy1, mosi1); end
        step(59);
        tests++; if (bits1[15:0] !== 16'hBFFF) begin fails++; $display("FAIL div1_data got %h want bfff", bits1[15:0]); end
        tests++; if (rise_cnt1 != 16 || busy_cnt1 != 35 || ldac_cnt1 != 1)
            begin fails++; $display("FAIL div1_timing rises %0d busy %0d ldac %0d want 16 35 1", rise_cnt1, busy_cnt1, ldac_cnt1); end
        ready1 = 1'b0;
        step(3);
    endtask

    task automatic test_busy_request();
        clear_stats();
        sample0 = 12'hA5C; ready0 = 1'b1;
        step(5);
        ready0 = 1'b0;
        step(5);
        sample0 = 12'h123; ready0 = 1'b1;
        step(190);
`ifdef SAMPLE_DAC_TX_SKID_EN
        tests++; if (bits0[31:0] !== 32'h7A5C7123) begin fails++; $display("FAIL busy_req_data got %h want 7a5c7123", bits0[31:0]); end
        tests++; if (rise_cnt0 != 32 || busy_cnt0 != 140 || max_run0 != 140)
            begin fails++; $display("FAIL busy_req_timing rises %0d busy %0d run %0d want 32 140 140", rise_cnt0, busy_cnt0, max_run0); end
        tests++; if (ovr_cnt0 != 0) begin fails++; $display("FAIL busy_req_overrun got %0d want 0", ovr_cnt0); end
`else
        tests++; if (bits0[15:0] !== 16'h7A5C) begin fails++; $display("FAIL busy_req_data got %h want 7a5c", bits0[15:0]); end
        tests++; if (rise_cnt0 != 16 || busy_cnt0 != 70)
            begin fails++; $display("FAIL busy_req_timing rises %0d busy %0d want 16 70", rise_cnt0, busy_cnt0); end
        tests++; if (ovr_cnt0 != 1) begin fails++; $display("FAIL busy_req_overrun got %0d want 1", ovr_cnt0); end
`endif
        ready0 = 1'b0;
        step(3);
    endtask

`ifdef SAMPLE_DAC_TX_SKID_EN
    task automatic test_skid_overwrite();
        clear_stats();
        sample0 = 12'hA5C; ready0 = 1'b1;
        step(5);  ready0 = 1'b0;
        step(5);  sample0 = 12'h123; ready0 = 1'b1;
        step(5);  ready0 = 1'b0;
        step(5);  sample0 = 12'h456; ready0 = 1'b1;
        step(180);
        tests++; if (bits0[31:0] !== 32'h7A5C7456) begin fails++; $display("FAIL skid_ovw_data got %h want 7a5c7456", bits0[31:0]); end
        tests++; if (ovr_cnt0 != 1 || rise_cnt0 != 32 || busy_cnt0 != 140)
            begin fails++; $display("FAIL skid_ovw_stats ovr %0d rises %0d busy %0d want 1 32 140", ovr_cnt0, rise_cnt0, busy_cnt0); end
        ready0 = 1'b0;
        step(3);
    endtask
`endif

    // The second edge is seen on the final LDAC cycle of the first frame.
    task automatic test_last_ldac();
        clear_stats();
        sample0 = 12'hA5C; ready0 = 1'b1;
        step(1);  ready0 = 1'b0;
        step(69);
        tests++; if (busy0 !== 1'b1 || ldacn0 !== 1'b0)
            begin fails++; $display("FAIL last_ldac_state busy=%b ldacn=%b want 1 0", busy0, ldacn0); end
        sample0 = 12'h2B7; ready0 = 1'b1;
        step(150);
`ifdef SAMPLE_DAC_TX_SKID_EN
        tests++; if (bits0[31:0] !== 32'h7A5C72B7 || max_run0 != 140 || ovr_cnt0 != 0)
            begin fails++; $display("FAIL last_ldac_result data %h run %0d ovr %0d want 7a5c72b7 140 0", bits0[31:0], max_run0, ovr_cnt0); end
`else
        tests++; if (bits0[15:0] !== 16'h7A5C || rise_cnt0 != 16 || busy_cnt0 != 70 || ovr_cnt0 != 1)
            begin fails++; $display("FAIL last_ldac_result data %h rises %0d busy %0d ovr %0d want 7a5c 16 70 1", bits0[15:0], rise_cnt0, busy_cnt0, ovr_cnt0); end
`endif
        ready0 = 1'b0;
        step(3);
    endtask

    task automatic test_reset_mid();
        sample0 = 12'h555; ready0 = 1'b1;
        step(20);
        tests++; if (busy0 !== 1'b1 || csn0 !== 1'b0)
            begin fails++; $display("FAIL mid_pre_reset busy=%b csn=%b want 1 0", busy0, csn0); end
        #2 rst = 1'b1;
        #1;
        tests++; if (csn0 !== 1'b1 || sclk0 !== 1'b0 || mosi0 !== 1'b0 || ldacn0 !== 1'b1 || busy0 !== 1'b0 || ovr0 !== 1'b0)
            begin fails++; $display("FAIL mid_reset_async csn%b sclk%b mosi%b ldacn%b busy%b ovr%b want 1 0 0 1 0 0",
                                    csn0, sclk0, mosi0, ldacn0, busy0, ovr0); end
        step(3);
        rst = 1'b0;
        clear_stats();
        step(100);
        tests++; if (busy_cnt0 != 0 || rise_cnt0 != 0)
            begin fails++; $display("FAIL mid_no_restart busy %0d rises %0d want 0 0", busy_cnt0, rise_cnt0); end
        ready0 = 1'b0;
        step(3);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single_frame();
        test_level_hold();
        test_config_div1();
        test_busy_request();
`ifdef SAMPLE_DAC_TX_SKID_EN
        test_skid_overwrite();
`endif
        test_last_ldac();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
